// File: rtl/jogador_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jogador_pkg
//  Brief    : Shared types, parameter defaults and helpers for the automatic
//             memory-game player.
//  Revision : 1.0 - initial release
// ============================================================================
package jogador_pkg;

    // Player FSM states; encodings are visible on db_estado
    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        OBSERVA   = 4'd1,
        ESPACO    = 4'd2,
        PRESSIONA = 4'd3,
        PROXIMA   = 4'd4,
        FIM       = 4'd5
    } estado_t;

    localparam int c_max_jogadas_padrao  = 16;
    localparam int c_gap_ciclos_padrao   = 4;
    localparam int c_press_ciclos_padrao = 4;

    // True when exactly one bit of a 4-bit LED/button word is set
    function automatic logic eh_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jogador_memoria.sv
`default_nettype none
// ============================================================================
//  Module   : jogador_memoria
//  Brief    : Register file holding the observed LED sequence.
//             Synchronous write, asynchronous read, no reset.
//  Revision : 1.0 - initial release
// ============================================================================
module jogador_memoria #(
    parameter int PROFUNDIDADE = 16,
    parameter int AW           = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [3:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [3:0]    o_rdata
);

    logic [3:0] r_mem [PROFUNDIDADE];

    // Store one LED word per accepted observation
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/jogador_automatico.sv
`default_nettype none
// ============================================================================
//  Module   : jogador_automatico
//  Brief    : Automatic player: records the LED sequence shown by the game and
//             replays it as timed button presses when given the turn, with an
//             optional deliberate mistake on the last press.
//  Revision : 1.0 - initial release
// ============================================================================
module jogador_automatico
    import jogador_pkg::*;
#(
    parameter int MAX_JOGADAS  = c_max_jogadas_padrao,
    parameter int GAP_CICLOS   = c_gap_ciclos_padrao,
    parameter int PRESS_CICLOS = c_press_ciclos_padrao
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [3:0] leds,
    input  logic       vez_jogador,
    input  logic       errar,
    output logic [3:0] botoes,
    output logic       jogando,
    output logic       overflow,
    output logic       erro_leds,
    output logic [3:0] db_estado,
    output logic [4:0] db_tamanho
);

    localparam int c_aw       = (MAX_JOGADAS > 1) ? $clog2(MAX_JOGADAS) : 1;
    localparam int c_fase_max = (GAP_CICLOS > PRESS_CICLOS) ? GAP_CICLOS : PRESS_CICLOS;
    localparam int c_fw       = $clog2(c_fase_max + 1);

    estado_t          r_estado, w_prox;
    logic [4:0]       r_len, r_idx;
    logic [c_fw-1:0]  r_fase;
    logic [3:0]       r_leds_ant, r_botoes;
    logic             r_vez_ant, r_errar, r_ovf, r_err;

    logic             w_led_subida, w_led_invalido, w_vez_subida;
    logic             w_gravar, w_set_ovf, w_set_err, w_inicia, w_limpa_len;
    logic             w_pressiona, w_ultima;
    logic [3:0]       w_mem_dado, w_valor_botao;

    jogador_memoria #(
        .PROFUNDIDADE (MAX_JOGADAS),
        .AW           (c_aw)
    ) u_memoria (
        .clk     (clock),
        .i_we    (w_gravar),
        .i_waddr (r_len[c_aw-1:0]),
        .i_wdata (leds),
        .i_raddr (r_idx[c_aw-1:0]),
        .o_rdata (w_mem_dado)
    );

    assign w_led_subida   = eh_onehot(leds) && (r_leds_ant == 4'd0);
    assign w_led_invalido = (leds != 4'd0) && !eh_onehot(leds);
    assign w_vez_subida   = vez_jogador && !r_vez_ant;
    assign w_ultima       = (r_idx == r_len - 5'd1);
    assign w_valor_botao  = (w_ultima && r_errar) ? {w_mem_dado[2:0], w_mem_dado[3]} : w_mem_dado;
    // Press is dropped the cycle after an abort or disable, not one cycle later
    assign w_pressiona    = (r_estado == PRESSIONA) && vez_jogador && habilita;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_prox;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_prox      = r_estado;
        w_gravar    = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_err   = 1'b0;
        w_inicia    = 1'b0;
        w_limpa_len = 1'b0;
        case (r_estado)
            INICIAL: begin
                if (habilita) w_prox = OBSERVA;
            end
            OBSERVA: begin
                if (w_led_subida) begin
                    if (r_len == 5'(MAX_JOGADAS)) w_set_ovf = 1'b1;
                    else                          w_gravar  = 1'b1;
                end
                if (w_led_invalido) w_set_err = 1'b1;
                // An LED stored on this same edge counts toward the round
                if (w_vez_subida) begin
                    if (w_gravar || (r_len != 5'd0)) begin
                        w_prox   = ESPACO;
                        w_inicia = 1'b1;
                    end else begin
                        w_prox = FIM;
                    end
                end
            end
            ESPACO: begin
                if (!vez_jogador) begin
                    w_prox      = OBSERVA;
                    w_limpa_len = 1'b1;
                end else if (r_fase == c_fw'(GAP_CICLOS - 1)) begin
                    w_prox = PRESSIONA;
                end
            end
            PRESSIONA: begin
                if (!vez_jogador) begin
                    w_prox      = OBSERVA;
                    w_limpa_len = 1'b1;
                end else if (r_fase == c_fw'(PRESS_CICLOS - 1)) begin
                    w_prox = PROXIMA;
                end
            end
            PROXIMA: begin
                if (!vez_jogador) begin
                    w_prox      = OBSERVA;
                    w_limpa_len = 1'b1;
                end else if (w_ultima) begin
                    w_prox = FIM;
                end else begin
                    w_prox = ESPACO;
                end
            end
            FIM: begin
                if (!vez_jogador) begin
                    w_prox      = OBSERVA;
                    w_limpa_len = 1'b1;
                end
            end
            default: w_prox = INICIAL;
        endcase
        if (!habilita) begin
            w_prox      = INICIAL;
            w_gravar    = 1'b0;
            w_set_ovf   = 1'b0;
            w_set_err   = 1'b0;
            w_inicia    = 1'b0;
            w_limpa_len = 1'b0;
        end
    end

    // Edge history, phase counter, sequence pointers, flags and button drive
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_leds_ant <= 4'd0;
            r_vez_ant  <= 1'b0;
            r_botoes   <= 4'd0;
            r_fase     <= '0;
            r_len      <= 5'd0;
            r_idx      <= 5'd0;
            r_errar    <= 1'b0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_leds_ant <= leds;
            r_vez_ant  <= vez_jogador;
            r_botoes   <= w_pressiona ? w_valor_botao : 4'd0;
            r_fase     <= (w_prox != r_estado) ? '0 : r_fase + 1'b1;
            if (r_estado == INICIAL) begin
                r_len   <= 5'd0;
                r_idx   <= 5'd0;
                r_errar <= 1'b0;
                r_ovf   <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                if (w_gravar)    r_len <= r_len + 5'd1;
                if (w_limpa_len) r_len <= 5'd0;
                if (w_set_ovf)   r_ovf <= 1'b1;
                if (w_set_err)   r_err <= 1'b1;
                if (w_inicia) begin
                    r_idx   <= 5'd0;
                    r_errar <= errar;
                end
                if (r_estado == PROXIMA) r_idx <= r_idx + 5'd1;
            end
        end
    end

    assign botoes     = r_botoes;
    assign jogando    = (r_estado == ESPACO) || (r_estado == PRESSIONA);
    assign overflow   = r_ovf;
    assign erro_leds  = r_err;
    assign db_estado  = r_estado;
    assign db_tamanho = r_len;

endmodule
`default_nettype wire

// File: tb/tb_jogador_automatico.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jogador_automatico
//  Brief    : Directed self-checking bench for jogador_automatico.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jogador_automatico;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic [3:0] leds;
    logic       vez_jogador;
    logic       errar;
    logic [3:0] botoes;
    logic       jogando;
    logic       overflow;
    logic       erro_leds;
    logic [3:0] db_estado;
    logic [4:0] db_tamanho;

    int total = 0;
    int bad   = 0;

    jogador_automatico dut (
        .clock       (clock),
        .reset       (reset),
        .habilita    (habilita),
        .leds        (leds),
        .vez_jogador (vez_jogador),
        .errar       (errar),
        .botoes      (botoes),
        .jogando     (jogando),
        .overflow    (overflow),
        .erro_leds   (erro_leds),
        .db_estado   (db_estado),
        .db_tamanho  (db_tamanho)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One LED flash: held for one cycle, then one dark cycle
    task automatic mostra_led(input logic [3:0] v);
        leds = v;
        @(negedge clock);
        leds = 4'd0;
        @(negedge clock);
    endtask

    // Button value expected j edges after the vez_jogador rise (GAP=4, PRESS=4)
    function automatic logic [3:0] exp_b(input int j, input logic [3:0] a,
                                         input logic [3:0] b, input logic [3:0] c);
        if (j >= 5  && j <= 8)  return a;
        if (j >= 14 && j <= 17) return b;
        if (j >= 23 && j <= 26) return c;
        return 4'd0;
    endfunction

    logic [3:0] v;

    initial begin
        reset = 1'b0; habilita = 1'b0; leds = 4'd0; vez_jogador = 1'b0; errar = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_botoes",  8'(botoes), 8'h0);
        chk("rst_jogando", 8'(jogando), 8'h0);
        chk("rst_ovf",     8'(overflow), 8'h0);
        chk("rst_err",     8'(erro_leds), 8'h0);
        chk("rst_estado",  8'(db_estado), 8'h0);
        chk("rst_tam",     8'(db_tamanho), 8'h0);

        reset = 1'b1; habilita = 1'b1;
        @(negedge clock);
        chk("hab_observa", 8'(db_estado), 8'h1);

        // Round: 0001, 0100, 1000 replayed without error
        mostra_led(4'b0001); mostra_led(4'b0100); mostra_led(4'b1000);
        chk("r1_tam", 8'(db_tamanho), 8'h3);
        vez_jogador = 1'b1;
        for (int j = 0; j < 28; j++) begin
            @(negedge clock);
            chk("r1_botoes", 8'(botoes), 8'(exp_b(j, 4'b0001, 4'b0100, 4'b1000)));
            if (j == 0)  chk("r1_jogando", 8'(jogando), 8'h1);
            if (j == 27) chk("r1_fim", 8'(db_estado), 8'h5);
        end
        vez_jogador = 1'b0;
        @(negedge clock);
        chk("r1_volta_obs", 8'(db_estado), 8'h1);
        chk("r1_tam_zero",  8'(db_tamanho), 8'h0);

        // Same round, last press deliberately wrong
        mostra_led(4'b0001); mostra_led(4'b0100); mostra_led(4'b1000);
        vez_jogador = 1'b1; errar = 1'b1;
        for (int j = 0; j < 28; j++) begin
            @(negedge clock);
            chk("r2_botoes", 8'(botoes), 8'(exp_b(j, 4'b0001, 4'b0100, 4'b0001)));
            errar = 1'b0;
        end
        vez_jogador = 1'b0;
        @(negedge clock);
        chk("r2_volta_obs", 8'(db_estado), 8'h1);

        // Abort during the second press
        mostra_led(4'b0001); mostra_led(4'b0100); mostra_led(4'b1000);
        vez_jogador = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clock);
            chk("r3_botoes", 8'(botoes), 8'(exp_b(j, 4'b0001, 4'b0100, 4'b1000)));
        end
        vez_jogador = 1'b0;
        @(negedge clock);
        chk("abort_botoes", 8'(botoes), 8'h0);
        chk("abort_estado", 8'(db_estado), 8'h1);
        chk("abort_tam",    8'(db_tamanho), 8'h0);

        // Invalid LED word and overflow
        mostra_led(4'b0010);
        chk("ok_tam1", 8'(db_tamanho), 8'h1);
        mostra_led(4'b0110);
        chk("inv_err", 8'(erro_leds), 8'h1);
        chk("inv_tam", 8'(db_tamanho), 8'h1);
        for (int i = 0; i < 15; i++) begin
            v = 4'b0001 << (i % 4);
            mostra_led(v);
        end
        chk("cheio_tam", 8'(db_tamanho), 8'h10);
        chk("cheio_ovf", 8'(overflow), 8'h0);
        mostra_led(4'b1000);
        chk("ovf_flag", 8'(overflow), 8'h1);
        chk("ovf_tam",  8'(db_tamanho), 8'h10);

        // Asynchronous reset in the middle of a press
        vez_jogador = 1'b1;
        for (int j = 0; j < 7; j++) @(negedge clock);
        chk("pre_rst_botoes", 8'(botoes), 8'h2);
        chk("pre_rst_estado", 8'(db_estado), 8'h3);
        #2;
        reset = 1'b0; vez_jogador = 1'b0;
        #1;
        chk("arst_botoes",  8'(botoes), 8'h0);
        chk("arst_estado",  8'(db_estado), 8'h0);
        chk("arst_jogando", 8'(jogando), 8'h0);
        chk("arst_ovf",     8'(overflow), 8'h0);
        chk("arst_err",     8'(erro_leds), 8'h0);
        chk("arst_tam",     8'(db_tamanho), 8'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("pos_rst_obs", 8'(db_estado), 8'h1);

        // LED and turn arrive on the same edge
        leds = 4'b0001; vez_jogador = 1'b1;
        @(negedge clock);
        leds = 4'd0;
        chk("mesmo_tam",    8'(db_tamanho), 8'h1);
        chk("mesmo_estado", 8'(db_estado), 8'h2);
        for (int j = 1; j < 10; j++) begin
            @(negedge clock);
            chk("mesmo_botoes", 8'(botoes), 8'(exp_b(j, 4'b0001, 4'b0000, 4'b0000)));
            if (j == 9) chk("mesmo_fim", 8'(db_estado), 8'h5);
        end
        vez_jogador = 1'b0;
        @(negedge clock);
        chk("mesmo_obs", 8'(db_estado), 8'h1);

        // Turn granted with nothing stored
        vez_jogador = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clock);
            chk("vazio_estado", 8'(db_estado), 8'h5);
            chk("vazio_botoes", 8'(botoes), 8'h0);
        end
        vez_jogador = 1'b0;
        @(negedge clock);
        chk("vazio_obs", 8'(db_estado), 8'h1);

        // Disable returns to the initial state
        habilita = 1'b0;
        @(negedge clock);
        chk("desab_estado", 8'(db_estado), 8'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
